// File: rtl/cnl_result_checker_if.sv
// Handshake bundle for cnl_result_checker: expected-value push port and DUT result port.
interface cnl_result_checker_if #(
  parameter int unsigned C_DATA_WIDTH = 16,
  parameter int unsigned C_CHAN_WIDTH = 2
);
  logic                    exp_valid;
  logic                    exp_ready;
  logic [C_CHAN_WIDTH-1:0] exp_chan;
  logic [C_DATA_WIDTH-1:0] exp_data;
  logic                    result_valid;
  logic                    result_accept;
  logic [C_CHAN_WIDTH-1:0] result_chan;
  logic [C_DATA_WIDTH-1:0] result_data;

  modport master (
    output exp_valid, exp_chan, exp_data, result_valid, result_chan, result_data,
    input  exp_ready, result_accept
  );

  modport slave (
    input  exp_valid, exp_chan, exp_data, result_valid, result_chan, result_data,
    output exp_ready, result_accept
  );
endinterface

// File: rtl/cnl_result_checker.sv
// Multi-channel convolution result checker: per-channel expected FIFOs, tolerant compare,
// pass/fail counters, first-error capture and stall timeout.
module cnl_result_checker #(
  parameter int unsigned C_DATA_WIDTH     = 16,
  parameter int unsigned C_NUM_CHANNELS   = 4,
  parameter int unsigned C_CHAN_WIDTH     = 2,
  parameter int unsigned C_FIFO_DEPTH     = 16,
  parameter int unsigned C_COUNT_WIDTH    = 32,
  parameter int unsigned C_TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     flush,
  input  logic [C_COUNT_WIDTH-1:0] cfg_total_results,
  input  logic [C_DATA_WIDTH-1:0]  cfg_tolerance,
  cnl_result_checker_if.slave      bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [C_COUNT_WIDTH-1:0] match_count,
  output logic [C_COUNT_WIDTH-1:0] mismatch_count,
  output logic                     first_err_valid,
  output logic [C_CHAN_WIDTH-1:0]  first_err_chan,
  output logic [C_COUNT_WIDTH-1:0] first_err_index,
  output logic [C_DATA_WIDTH-1:0]  first_err_exp,
  output logic [C_DATA_WIDTH-1:0]  first_err_act
);

  localparam int unsigned C_PTR_WIDTH = $clog2(C_FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   r_state;
  logic [C_COUNT_WIDTH-1:0] r_total;
  logic [C_DATA_WIDTH-1:0]  r_tol;
  logic                     r_done;
  logic                     r_pass;
  logic                     r_timeout;
  logic [C_COUNT_WIDTH-1:0] r_match;
  logic [C_COUNT_WIDTH-1:0] r_mismatch;
  logic [C_COUNT_WIDTH-1:0] r_tmo_cnt;
  logic                     r_ferr_valid;
  logic [C_CHAN_WIDTH-1:0]  r_ferr_chan;
  logic [C_COUNT_WIDTH-1:0] r_ferr_index;
  logic [C_DATA_WIDTH-1:0]  r_ferr_exp;
  logic [C_DATA_WIDTH-1:0]  r_ferr_act;
  logic [C_COUNT_WIDTH-1:0] r_idx [C_NUM_CHANNELS];

  logic [C_DATA_WIDTH-1:0]  r_mem  [C_NUM_CHANNELS][C_FIFO_DEPTH];
  logic [C_PTR_WIDTH:0]     r_wptr [C_NUM_CHANNELS];
  logic [C_PTR_WIDTH:0]     r_rptr [C_NUM_CHANNELS];

  logic [C_NUM_CHANNELS-1:0] w_full;
  logic [C_NUM_CHANNELS-1:0] w_empty;
  logic                      w_exp_chan_ok;
  logic                      w_res_chan_ok;
  logic                      w_flush;
  logic                      w_push;
  logic                      w_hs;
  logic [C_DATA_WIDTH-1:0]   w_exp_head;
  logic signed [C_DATA_WIDTH:0] w_diff;
  logic [C_DATA_WIDTH:0]     w_abs;
  logic                      w_match;
  logic [C_COUNT_WIDTH:0]    w_sum;

  function automatic logic [C_COUNT_WIDTH-1:0] f_sat_inc(input logic [C_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Extra pointer MSB distinguishes full from empty when the index bits coincide.
  for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_flags
    assign w_empty[c] = (r_wptr[c] == r_rptr[c]);
    assign w_full[c]  = (r_wptr[c][C_PTR_WIDTH] != r_rptr[c][C_PTR_WIDTH]) &&
                        (r_wptr[c][C_PTR_WIDTH-1:0] == r_rptr[c][C_PTR_WIDTH-1:0]);
  end

  assign w_exp_chan_ok     = 32'(bus.exp_chan) < C_NUM_CHANNELS;
  assign w_res_chan_ok     = 32'(bus.result_chan) < C_NUM_CHANNELS;
  assign w_flush           = flush && (r_state != StRun);
  assign bus.exp_ready     = w_exp_chan_ok && !w_full[bus.exp_chan] && !w_flush;
  assign w_push            = bus.exp_valid && bus.exp_ready;
  assign bus.result_accept = (r_state == StRun) && w_res_chan_ok && !w_empty[bus.result_chan];
  assign w_hs              = bus.result_valid && bus.result_accept;

  assign w_exp_head = r_mem[bus.result_chan][r_rptr[bus.result_chan][C_PTR_WIDTH-1:0]];

  // One extra bit keeps the full signed difference range, so |diff| never wraps.
  always_comb begin
    w_diff  = $signed({bus.result_data[C_DATA_WIDTH-1], bus.result_data}) -
              $signed({w_exp_head[C_DATA_WIDTH-1], w_exp_head});
    w_abs   = w_diff[C_DATA_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_match = (w_abs <= {1'b0, r_tol});
  end

  assign w_sum = {1'b0, r_match} + {1'b0, r_mismatch};

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else if (w_flush) begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < C_NUM_CHANNELS; c++) begin
        if (w_push && (bus.exp_chan == C_CHAN_WIDTH'(c))) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_hs && (bus.result_chan == C_CHAN_WIDTH'(c))) r_rptr[c] <= r_rptr[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_if) begin
    if (w_push) begin
      r_mem[bus.exp_chan][r_wptr[bus.exp_chan][C_PTR_WIDTH-1:0]] <= bus.exp_data;
    end
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_total      <= '0;
      r_tol        <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_match      <= '0;
      r_mismatch   <= '0;
      r_tmo_cnt    <= '0;
      r_ferr_valid <= 1'b0;
      r_ferr_chan  <= '0;
      r_ferr_index <= '0;
      r_ferr_exp   <= '0;
      r_ferr_act   <= '0;
      for (int c = 0; c < C_NUM_CHANNELS; c++) r_idx[c] <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state      <= StRun;
            r_total      <= cfg_total_results;
            r_tol        <= cfg_tolerance;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_match      <= '0;
            r_mismatch   <= '0;
            r_tmo_cnt    <= '0;
            r_ferr_valid <= 1'b0;
            r_ferr_chan  <= '0;
            r_ferr_index <= '0;
            r_ferr_exp   <= '0;
            r_ferr_act   <= '0;
            for (int c = 0; c < C_NUM_CHANNELS; c++) r_idx[c] <= '0;
          end
        end
        StRun: begin
          if (w_hs) begin
            r_tmo_cnt <= '0;
            r_idx[bus.result_chan] <= f_sat_inc(r_idx[bus.result_chan]);
            if (w_match) begin
              r_match <= f_sat_inc(r_match);
            end else begin
              r_mismatch <= f_sat_inc(r_mismatch);
              if (!r_ferr_valid) begin
                r_ferr_valid <= 1'b1;
                r_ferr_chan  <= bus.result_chan;
                r_ferr_index <= r_idx[bus.result_chan];
                r_ferr_exp   <= w_exp_head;
                r_ferr_act   <= bus.result_data;
              end
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
          // Completion is judged on the registered counts, one edge after the last compare.
          if (w_sum >= {1'b0, r_total}) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_pass  <= (r_mismatch == '0);
          end else if (!w_hs && (r_tmo_cnt == C_COUNT_WIDTH'(C_TIMEOUT_CYCLES - 1))) begin
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy            = (r_state == StRun);
  assign done            = r_done;
  assign pass            = r_pass;
  assign timeout         = r_timeout;
  assign match_count     = r_match;
  assign mismatch_count  = r_mismatch;
  assign first_err_valid = r_ferr_valid;
  assign first_err_chan  = r_ferr_chan;
  assign first_err_index = r_ferr_index;
  assign first_err_exp   = r_ferr_exp;
  assign first_err_act   = r_ferr_act;

endmodule

// File: tb/tb_cnl_result_checker.sv
// Directed bench for cnl_result_checker: table of single-compare runs plus multi-cycle sequences.
module tb_cnl_result_checker;

  logic        clk_if = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] cfg_total_results = '0;
  logic [15:0] cfg_tolerance = '0;
  logic        busy, done, pass, timeout, first_err_valid;
  logic [31:0] match_count, mismatch_count, first_err_index;
  logic [1:0]  first_err_chan;
  logic [15:0] first_err_exp, first_err_act;

  int n_checks = 0;
  int n_errors = 0;

  cnl_result_checker_if #(.C_DATA_WIDTH(16), .C_CHAN_WIDTH(2)) bus ();

  cnl_result_checker dut (
    .clk_if            (clk_if),
    .rst               (rst),
    .start             (start),
    .flush             (flush),
    .cfg_total_results (cfg_total_results),
    .cfg_tolerance     (cfg_tolerance),
    .bus               (bus),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout           (timeout),
    .match_count       (match_count),
    .mismatch_count    (mismatch_count),
    .first_err_valid   (first_err_valid),
    .first_err_chan    (first_err_chan),
    .first_err_index   (first_err_index),
    .first_err_exp     (first_err_exp),
    .first_err_act     (first_err_act)
  );

  always #5 clk_if = ~clk_if;

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] exp_v;
    logic [15:0] act_v;
    logic [15:0] tol;
    logic        is_match;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [15:0] d);
    int n = 0;
    bus.exp_valid = 1'b1;
    bus.exp_chan  = c;
    bus.exp_data  = d;
    #1;
    while (!bus.exp_ready && n < 100) begin
      @(posedge clk_if); #2;
      n++;
    end
    if (!bus.exp_ready) check("push_ready_wait", 64'(bus.exp_ready), 64'd1);
    @(posedge clk_if); #1;
    bus.exp_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] d);
    int n = 0;
    bus.result_valid = 1'b1;
    bus.result_chan  = c;
    bus.result_data  = d;
    #1;
    while (!bus.result_accept && n < 100) begin
      @(posedge clk_if); #2;
      n++;
    end
    if (!bus.result_accept) check("send_accept_wait", 64'(bus.result_accept), 64'd1);
    @(posedge clk_if); #1;
    bus.result_valid = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] total, input logic [15:0] tol, input logic fl);
    start = 1'b1;
    flush = fl;
    cfg_total_results = total;
    cfg_tolerance = tol;
    @(posedge clk_if); #1;
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(posedge clk_if); #1;
      n++;
    end
    if (!done) check("wait_done_bound", 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    bus.exp_valid    = 1'b0;
    bus.exp_chan     = '0;
    bus.exp_data     = '0;
    bus.result_valid = 1'b0;
    bus.result_chan  = '0;
    bus.result_data  = '0;

    // Signed values stored as raw 16-bit patterns (e.g. FFFB = -5).
    vecs[0] = '{2'd0, 16'h0005, 16'h0005, 16'h0000, 1'b1};
    vecs[1] = '{2'd0, 16'h0005, 16'h0006, 16'h0000, 1'b0};
    vecs[2] = '{2'd1, 16'hFFFB, 16'hFFFD, 16'h0002, 1'b1};
    vecs[3] = '{2'd1, 16'hFFFB, 16'hFFF8, 16'h0002, 1'b0};
    vecs[4] = '{2'd2, 16'd100,  16'd97,   16'h0003, 1'b1};
    vecs[5] = '{2'd2, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};
    vecs[6] = '{2'd3, 16'h7FFF, 16'h8000, 16'hFFFE, 1'b0};
    vecs[7] = '{2'd3, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    vecs[8] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[9] = '{2'd1, 16'h0000, 16'hFFFF, 16'h0001, 1'b1};

    repeat (2) @(posedge clk_if);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_match", 64'(match_count), 64'd0);
    check("rst_accept", 64'(bus.result_accept), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].chan, vecs[i].exp_v);
      do_start(32'd1, vecs[i].tol, 1'b0);
      send(vecs[i].chan, vecs[i].act_v);
      wait_done(20);
      check($sformatf("vec%0d_match", i), 64'(match_count), 64'(vecs[i].is_match));
      check($sformatf("vec%0d_mismatch", i), 64'(mismatch_count), 64'(!vecs[i].is_match));
      check($sformatf("vec%0d_pass", i), 64'(pass), 64'(vecs[i].is_match));
      check($sformatf("vec%0d_ferr_valid", i), 64'(first_err_valid), 64'(!vecs[i].is_match));
      check($sformatf("vec%0d_ferr_act", i), 64'(first_err_act),
            vecs[i].is_match ? 64'd0 : 64'(vecs[i].act_v));
    end

    // Three in-order matches; done lags the final compare by one edge.
    push(2'd0, 16'd1); push(2'd0, 16'd2); push(2'd0, 16'd3);
    do_start(32'd3, 16'd0, 1'b0);
    send(2'd0, 16'd1); send(2'd0, 16'd2); send(2'd0, 16'd3);
    check("seqA_match", 64'(match_count), 64'd3);
    check("seqA_done_lag", 64'(done), 64'd0);
    @(posedge clk_if); #1;
    check("seqA_done", 64'(done), 64'd1);
    check("seqA_pass", 64'(pass), 64'd1);
    check("seqA_mismatch", 64'(mismatch_count), 64'd0);
    check("seqA_busy", 64'(busy), 64'd0);

    // Tolerance 2: -5 vs -3 matches, 100 vs 103 is the first error at index 1.
    push(2'd0, 16'hFFFB); push(2'd0, 16'd100);
    do_start(32'd2, 16'd2, 1'b0);
    send(2'd0, 16'hFFFD); send(2'd0, 16'd103);
    wait_done(20);
    check("seqB_match", 64'(match_count), 64'd1);
    check("seqB_mismatch", 64'(mismatch_count), 64'd1);
    check("seqB_ferr_chan", 64'(first_err_chan), 64'd0);
    check("seqB_ferr_index", 64'(first_err_index), 64'd1);
    check("seqB_ferr_exp", 64'(first_err_exp), 64'd100);
    check("seqB_ferr_act", 64'(first_err_act), 64'd103);
    check("seqB_pass", 64'(pass), 64'd0);

    // Fill all four channels, then interleave results ch3,ch0,ch2,ch1.
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 16; i++) push(2'(c), 16'(c * 256 + i));
    bus.exp_valid = 1'b1; bus.exp_chan = 2'd0; bus.exp_data = 16'hDEAD;
    #1;
    check("seqC_full_ready", 64'(bus.exp_ready), 64'd0);
    do_start(32'd64, 16'd0, 1'b0);
    check("seqC_full_ready_run", 64'(bus.exp_ready), 64'd0);
    for (int i = 0; i < 16; i++) begin
      send(2'd3, 16'(3 * 256 + i));
      if (i == 0) begin
        bus.result_valid = 1'b1; bus.result_chan = 2'd0; bus.result_data = 16'd0;
        #1;
        check("seqC_pop_accept", 64'(bus.result_accept), 64'd1);
        check("seqC_push_while_pop", 64'(bus.exp_ready), 64'd0);
        @(posedge clk_if); #1;
        bus.result_valid = 1'b0;
        check("seqC_ready_after_pop", 64'(bus.exp_ready), 64'd1);
        bus.exp_valid = 1'b0;
      end else begin
        send(2'd0, 16'(i));
      end
      send(2'd2, 16'(2 * 256 + i));
      send(2'd1, 16'(1 * 256 + i));
    end
    wait_done(20);
    check("seqC_match", 64'(match_count), 64'd64);
    check("seqC_mismatch", 64'(mismatch_count), 64'd0);
    check("seqC_pass", 64'(pass), 64'd1);

    // Empty channel holds accept low; a push shows up one cycle later; then stall to timeout.
    do_start(32'd1, 16'd0, 1'b0);
    bus.result_valid = 1'b1; bus.result_chan = 2'd1; bus.result_data = 16'd7;
    #1;
    check("seqD_empty_accept", 64'(bus.result_accept), 64'd0);
    bus.exp_valid = 1'b1; bus.exp_chan = 2'd1; bus.exp_data = 16'd7;
    #1;
    check("seqD_push_cycle_accept", 64'(bus.result_accept), 64'd0);
    @(posedge clk_if); #1;
    bus.exp_valid = 1'b0;
    check("seqD_accept_after_push", 64'(bus.result_accept), 64'd1);
    bus.result_valid = 1'b0;
    n = 1;
    while (!done && n < 5000) begin
      @(posedge clk_if); #1;
      n++;
    end
    check("seqD_timeout_cycles", 64'(n), 64'd4096);
    check("seqD_timeout", 64'(timeout), 64'd1);
    check("seqD_done", 64'(done), 64'd1);
    check("seqD_pass", 64'(pass), 64'd0);
    check("seqD_match", 64'(match_count), 64'd0);

    // Mid-run reset after 10 compares (5th one wrong) clears everything.
    for (int i = 0; i < 12; i++) push(2'd0, 16'(i + 40));
    do_start(32'd12, 16'd0, 1'b0);
    for (int i = 0; i < 10; i++) send(2'd0, 16'(i + 40 + ((i == 4) ? 1 : 0)));
    check("seqE_pre_mismatch", 64'(mismatch_count), 64'd1);
    rst = 1'b1;
    #1;
    check("seqE_busy", 64'(busy), 64'd0);
    check("seqE_match", 64'(match_count), 64'd0);
    check("seqE_mismatch", 64'(mismatch_count), 64'd0);
    check("seqE_ferr_valid", 64'(first_err_valid), 64'd0);
    check("seqE_ferr_act", 64'(first_err_act), 64'd0);
    #1;
    rst = 1'b0;
    do_start(32'd0, 16'd0, 1'b0);
    bus.result_valid = 1'b1; bus.result_chan = 2'd0;
    #1;
    check("seqE_fifo_empty", 64'(bus.result_accept), 64'd0);
    bus.result_valid = 1'b0;
    @(posedge clk_if); #1;
    check("seqE_zero_done", 64'(done), 64'd1);
    check("seqE_zero_pass", 64'(pass), 64'd1);

    // Flush together with start clears a preloaded word; total=0 finishes one edge after entry.
    push(2'd3, 16'h0055);
    do_start(32'd0, 16'd0, 1'b1);
    check("seqF_busy", 64'(busy), 64'd1);
    check("seqF_done_lag", 64'(done), 64'd0);
    bus.result_valid = 1'b1; bus.result_chan = 2'd3;
    #1;
    check("seqF_flushed", 64'(bus.result_accept), 64'd0);
    bus.result_valid = 1'b0;
    @(posedge clk_if); #1;
    check("seqF_done", 64'(done), 64'd1);
    check("seqF_pass", 64'(pass), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
